id_scoreboard_hazard: RTL and testbench
=======================================

Name: id_scoreboard_hazard

Overview:
- Parametrised hazard-detection unit for the ID stage; generalises the single-cycle load-use check to a per-register scoreboard with configurable result latencies (ALU, load, multiply, divide).
- Drives Stall/IFWrite, issues the ID instruction, cancels the scoreboard entry of an instruction flushed from EX, and keeps a saturating stall-cycle statistic.
- Sits beside the register file in ID; consumes decoded rs1/rs2/rd addresses and a latency class.

Parameters:
- AW, 5, register address width; NREGS = 2**AW entries, entry 0 never tracked.
- LOAD_LAT, 1, bubbles required after a load before a dependent instruction may issue.
- MUL_LAT, 2, bubbles after a multiply.
- DIV_LAT, 8, bubbles after a divide.
- CW, 4, scoreboard counter width; must hold max latency (checked by elaboration assertion).
- SW, 16, stall statistic counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  valid instruction in ID.
- rs1Addr_id  in  AW  source 1 address.
- rs2Addr_id  in  AW  source 2 address.
- rs1_used  in  1  instruction reads rs1.
- rs2_used  in  1  instruction reads rs2.
- rd_we_id  in  1  instruction writes rd.
- rdAddr_id  in  AW  destination address.
- lat_class_id  in  2  0=ALU(0 bubbles), 1=LOAD, 2=MUL, 3=DIV.
- flush_ex  in  1  kill instructions in EX and ID this cycle.
- Stall  out  1  hold PC and IF/ID register.
- IFWrite  out  1  equals ~Stall.
- id_issue  out  1  ID instruction advances to EX this cycle.
- busy_mask  out  NREGS  bit r = scoreboard counter r nonzero.
- stall_cycles  out  SW  saturating count of Stall-asserted cycles.

Behaviour:
- State: cnt[r] (CW bits, r=1..NREGS-1), last_we (1), last_rd (AW), stall_cycles. All reset to 0 asynchronously on rst_n low, regardless of other inputs; cnt[0] is constant 0.
- hz1 = rs1_used & (rs1Addr_id!=0) & (cnt[rs1Addr_id]!=0); hz2 likewise for rs2.
- Stall = id_valid & ~flush_ex & (hz1 | hz2); combinational from current-cycle state; IFWrite = ~Stall.
- id_issue = id_valid & ~Stall & ~flush_ex.
- lat(class) = 0, LOAD_LAT, MUL_LAT, DIV_LAT.
- Per cycle, for each r: next = (cnt[r]!=0) ? cnt[r]-1 : 0.
- Flush cancel: if flush_ex & last_we, next[last_rd] = 0 (the EX-stage instruction issued last cycle never writes).
- Issue: if id_issue & rd_we_id & rdAddr_id!=0: next[rdAddr_id] = max(lat(class), decremented value) (WAW keeps the longer pending result). Issue has priority over decrement; flush suppresses issue, so issue and flush-cancel never coincide.
- last_we <= id_issue & rd_we_id & (rdAddr_id!=0); last_rd <= rdAddr_id.
- Result: a dependent instruction issued directly after a producer of latency L sees exactly L stall cycles; ALU producers never stall (forwarding assumed).
- busy_mask is registered state (bit r = cnt[r]!=0).
- stall_cycles increments when Stall=1, holds at all-ones.
- Self-dependency (rs==rd) on the current instruction never stalls against itself.
- rd=0 writes and rs=0 reads are ignored.

Test Plan:
- Reset: drive rst_n=0 mid-run with cnt[5]=3 -> immediately busy_mask=0, Stall=0, stall_cycles=0, IFWrite=1.
- Load-use: issue LOAD rd=5, next cycle rs1=5 used -> Stall=1 for 1 cycle, id_issue=1 on 2nd cycle; stall_cycles=1.
- DIV chain: issue DIV rd=7, then rs2=7 -> Stall=1 for exactly 8 cycles, busy_mask[7] drops when cnt reaches 0; rs2_used=0 with same address -> no stall.
- WAW: DIV rd=3 then ALU rd=3 next cycle -> cnt[3] stays 7 (not 0); dependent on x3 stalls 7 cycles.
- Flush: issue MUL rd=9, next cycle flush_ex=1 with id_valid=1 dependent on x9 -> Stall=0, id_issue=0, cnt[9]=0 next cycle.
- x0 and saturation: LOAD rd=0 then rs1=0 -> no stall; hold a stall 2**SW+5 cycles (SW=4 override) -> stall_cycles=15.

Source files
------------

// File: rtl/id_scoreboard_hazard.sv
// ID-stage hazard unit: per-register latency scoreboard driving Stall/IFWrite,
// with flush cancellation of the EX-stage producer and a saturating stall counter.
module id_scoreboard_hazard #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int CW       = 4,
  parameter int SW       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [AW-1:0]     rs1Addr_id,
  input  logic [AW-1:0]     rs2Addr_id,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              rd_we_id,
  input  logic [AW-1:0]     rdAddr_id,
  input  logic [1:0]        lat_class_id,
  input  logic              flush_ex,
  output logic              Stall,
  output logic              IFWrite,
  output logic              id_issue,
  output logic [2**AW-1:0]  busy_mask,
  output logic [SW-1:0]     stall_cycles
);

  localparam int unsigned NREGS = 2**AW;
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT)
                         ? ((DIV_LAT > LOAD_LAT) ? DIV_LAT : LOAD_LAT)
                         : ((MUL_LAT > LOAD_LAT) ? MUL_LAT : LOAD_LAT);

  if (MAX_LAT > (2**CW) - 1) begin : g_cw_check
    $error("id_scoreboard_hazard: CW too narrow for the largest latency");
  end

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_DIV  = 2'd3
  } lat_class_e;

  logic [CW-1:0] cnt      [NREGS];
  logic [CW-1:0] cnt_next [NREGS];
  logic          last_we;
  logic [AW-1:0] last_rd;
  logic          hz1, hz2;
  logic          rd_track;
  logic [CW-1:0] issue_lat;

  assign hz1 = rs1_used && (rs1Addr_id != '0) && (cnt[rs1Addr_id] != '0);
  assign hz2 = rs2_used && (rs2Addr_id != '0) && (cnt[rs2Addr_id] != '0);

  assign Stall    = id_valid && !flush_ex && (hz1 || hz2);
  assign IFWrite  = !Stall;
  assign id_issue = id_valid && !Stall && !flush_ex;
  assign rd_track = id_issue && rd_we_id && (rdAddr_id != '0);

  always_comb begin
    issue_lat = '0;
    case (lat_class_e'(lat_class_id))
      LAT_ALU:  issue_lat = '0;
      LAT_LOAD: issue_lat = CW'(LOAD_LAT);
      LAT_MUL:  issue_lat = CW'(MUL_LAT);
      LAT_DIV:  issue_lat = CW'(DIV_LAT);
      default:  issue_lat = '0;
    endcase
  end

  // Issue and flush-cancel are mutually exclusive (flush blocks issue), so
  // applying them in sequence after the decrement is order-independent.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_next[r] = (cnt[r] != '0) ? cnt[r] - CW'(1) : '0;
    end
    if (flush_ex && last_we) begin
      cnt_next[last_rd] = '0;
    end
    if (rd_track) begin
      cnt_next[rdAddr_id] = (issue_lat > cnt_next[rdAddr_id]) ? issue_lat
                                                              : cnt_next[rdAddr_id];
    end
    cnt_next[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
      last_we      <= 1'b0;
      last_rd      <= '0;
      stall_cycles <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt[r] <= cnt_next[r];
      end
      last_we <= rd_track;
      last_rd <= rdAddr_id;
      if (Stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + SW'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      busy_mask[r] = (cnt[r] != '0);
    end
  end

endmodule

// File: tb/tb_id_scoreboard_hazard.sv
// Directed bench for id_scoreboard_hazard: default instance plus an SW=4 instance
// sharing the same stimulus for the saturation check.
module tb_id_scoreboard_hazard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  rs1Addr_id, rs2Addr_id, rdAddr_id;
  logic        rs1_used, rs2_used, rd_we_id;
  logic [1:0]  lat_class_id;
  logic        flush_ex;

  logic        Stall, IFWrite, id_issue;
  logic [31:0] busy_mask;
  logic [15:0] stall_cycles;

  logic        s_Stall, s_IFWrite, s_id_issue;
  logic [31:0] s_busy_mask;
  logic [3:0]  s_stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  id_scoreboard_hazard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_we_id(rd_we_id), .rdAddr_id(rdAddr_id),
    .lat_class_id(lat_class_id), .flush_ex(flush_ex),
    .Stall(Stall), .IFWrite(IFWrite), .id_issue(id_issue),
    .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  id_scoreboard_hazard #(.SW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_we_id(rd_we_id), .rdAddr_id(rdAddr_id),
    .lat_class_id(lat_class_id), .flush_ex(flush_ex),
    .Stall(s_Stall), .IFWrite(s_IFWrite), .id_issue(s_id_issue),
    .busy_mask(s_busy_mask), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Apply one ID-stage vector at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic we,
                       input logic [4:0] rd, input logic [1:0] cls, input logic fl);
    @(negedge clk);
    id_valid = v; rs1Addr_id = r1; rs1_used = u1; rs2Addr_id = r2; rs2_used = u2;
    rd_we_id = we; rdAddr_id = rd; lat_class_id = cls; flush_ex = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; rs1Addr_id = '0; rs2Addr_id = '0; rdAddr_id = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rd_we_id = 1'b0; lat_class_id = '0; flush_ex = 1'b0;
    #1;
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_ifwrite", {31'd0, IFWrite}, 32'd1);
    chk("rst_sc", {16'd0, stall_cycles}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Load-use: LOAD x5, then reader of x5 stalls exactly one cycle
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd1, 1'b0);
    chk("load_issue", {31'd0, id_issue}, 32'd1);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    chk("lu_stall", {31'd0, Stall}, 32'd1);
    chk("lu_ifwrite", {31'd0, IFWrite}, 32'd0);
    chk("lu_noissue", {31'd0, id_issue}, 32'd0);
    chk("lu_busy5", {31'd0, busy_mask[5]}, 32'd1);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    chk("lu_release", {31'd0, Stall}, 32'd0);
    chk("lu_issue2", {31'd0, id_issue}, 32'd1);
    chk("lu_sc", {16'd0, stall_cycles}, 32'd1);
    idle();

    // DIV x7, reader on rs2 waits DIV_LAT cycles
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'd3, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
      if (i == 0) chk("div_busy7", {31'd0, busy_mask[7]}, 32'd1);
      if (!Stall) break;
      n++;
    end
    chk("div_stalls", n, 32'd8);
    chk("div_busy7_drop", {31'd0, busy_mask[7]}, 32'd0);
    chk("div_issue", {31'd0, id_issue}, 32'd1);
    chk("div_sc", {16'd0, stall_cycles}, 32'd9);
    idle();

    // WAW: DIV x3 then ALU x3 keeps the longer pending result
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'd0, 1'b0);
    chk("waw_alu_issue", {31'd0, id_issue}, 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
      if (!Stall) break;
      n++;
    end
    chk("waw_stalls", n, 32'd7);
    chk("waw_sc", {16'd0, stall_cycles}, 32'd16);
    idle();

    // Flush cancels the EX producer and suppresses the ID instruction
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 2'd2, 1'b0);
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 2'd3, 1'b1);
    chk("fl_stall", {31'd0, Stall}, 32'd0);
    chk("fl_issue", {31'd0, id_issue}, 32'd0);
    chk("fl_busy9_pre", {31'd0, busy_mask[9]}, 32'd1);
    idle();
    chk("fl_busy", busy_mask, 32'h0);
    chk("fl_sc", {16'd0, stall_cycles}, 32'd16);

    // x0 is never tracked
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 2'd1, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
    chk("x0_stall", {31'd0, Stall}, 32'd0);
    chk("x0_busy", busy_mask, 32'h0);

    // Unused rs2 with a busy address does not stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    chk("rs2_unused_stall", {31'd0, Stall}, 32'd0);
    chk("rs2_unused_issue", {31'd0, id_issue}, 32'd1);

    // Self-dependency: reads and writes x12 in one instruction
    drive(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 1'b1, 5'd12, 2'd3, 1'b0);
    chk("self_dep_stall", {31'd0, Stall}, 32'd0);
    idle();

    // Mid-run async reset with cnt[5]=3 and a pending dependent
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd3, 1'b0);
    repeat (5) idle();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    chk("pre_rst_stall", {31'd0, Stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_mask, 32'h0);
    chk("mid_rst_stall", {31'd0, Stall}, 32'd0);
    chk("mid_rst_ifwrite", {31'd0, IFWrite}, 32'd1);
    chk("mid_rst_sc", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Self-chaining DIV on x4: 27 cycles give 3 issues and 24 stalls
    for (int i = 0; i < 27; i++) begin
      drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 2'd3, 1'b0);
    end
    idle();
    chk("sat_main_sc", {16'd0, stall_cycles}, 32'd24);
    chk("sat_small_sc", {28'd0, s_stall_cycles}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
